regfile_ctrl: RTL and testbench

REGFILE_CTRL -- requirements
Module: regfile_ctrl

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_bypass.sv | 26 ++
 rtl/regfile_ctrl.sv | 128 ++++++++++++
 tb/tb_regfile_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file controller.
// req_t is the default-configuration request layout; the top rebuilds it at its parameter widths.
package regfile_pkg;

  localparam int DEF_ADDR  = 5;
  localparam int DEF_BUS_W = 32;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef struct packed {
    logic                 we;
    logic [DEF_ADDR-1:0]  waddr;
    logic [DEF_BUS_W-1:0] wdata;
    logic [DEF_ADDR-1:0]  raddr_a;
    logic [DEF_ADDR-1:0]  raddr_b;
  } req_t;

endpackage

// File: rtl/regfile_bypass.sv
// Per-port read mux: register 0 reads as zero, a same-cycle write to the read address wins.
// Purely combinational, no latency, no flow control.
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int ADDR  = DEF_ADDR,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic [ADDR-1:0]  raddr,
  input  logic [BUS_W-1:0] rf_data,
  input  logic             we,
  input  logic [ADDR-1:0]  waddr,
  input  logic [BUS_W-1:0] wdata,
  output logic [BUS_W-1:0] data
);

  always_comb begin
    data = rf_data;
    if (raddr == '0) begin
      data = '0;
    end else if (we && (waddr != '0) && (raddr == waddr)) begin
      data = wdata;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file front end: clears regs 1..N-1 after reset, then serves one read/write request per 3 cycles.
// Response appears in the second cycle after acceptance; rsp is held until rsp_ready, req_ready only in IDLE.
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int ADDR  = DEF_ADDR,
  parameter int BUS_W = DEF_BUS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDR-1:0]  req_waddr,
  input  logic [BUS_W-1:0] req_wdata,
  input  logic [ADDR-1:0]  req_raddr_a,
  input  logic [ADDR-1:0]  req_raddr_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [BUS_W-1:0] rsp_data_a,
  output logic [BUS_W-1:0] rsp_data_b,
  output logic             init_done,
  output logic             r_write,
  output logic [ADDR-1:0]  rd_addr,
  output logic [BUS_W-1:0] rd_w_data,
  output logic [ADDR-1:0]  rs_addr,
  output logic [ADDR-1:0]  rt_addr,
  input  logic [BUS_W-1:0] rs_data,
  input  logic [BUS_W-1:0] rt_data
);

  typedef struct packed {
    logic             we;
    logic [ADDR-1:0]  waddr;
    logic [BUS_W-1:0] wdata;
    logic [ADDR-1:0]  raddr_a;
    logic [ADDR-1:0]  raddr_b;
  } req_lat_t;

  state_t           state;
  req_lat_t         req_q;
  logic [ADDR-1:0]  sweep_cnt;
  logic [BUS_W-1:0] byp_a;
  logic [BUS_W-1:0] byp_b;

  regfile_bypass #(.ADDR(ADDR), .BUS_W(BUS_W)) u_byp_a (
    .raddr   (req_q.raddr_a),
    .rf_data (rs_data),
    .we      (req_q.we),
    .waddr   (req_q.waddr),
    .wdata   (req_q.wdata),
    .data    (byp_a)
  );

  regfile_bypass #(.ADDR(ADDR), .BUS_W(BUS_W)) u_byp_b (
    .raddr   (req_q.raddr_b),
    .rf_data (rt_data),
    .we      (req_q.we),
    .waddr   (req_q.waddr),
    .wdata   (req_q.wdata),
    .data    (byp_b)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= INIT;
      sweep_cnt  <= ADDR'(1);
      req_q      <= '0;
      init_done  <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      r_write    <= 1'b0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
      rd_addr    <= '0;
      rd_w_data  <= '0;
      rs_addr    <= '0;
      rt_addr    <= '0;
    end else begin
      case (state)
        INIT: begin
          // The last sweep write is retiring on this edge when it targets the top address.
          if (r_write && (rd_addr == '1)) begin
            r_write   <= 1'b0;
            init_done <= 1'b1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            r_write   <= 1'b1;
            rd_addr   <= sweep_cnt;
            rd_w_data <= '0;
            sweep_cnt <= sweep_cnt + ADDR'(1);
          end
        end
        IDLE: begin
          r_write <= 1'b0;
          if (req_valid && req_ready) begin
            req_q     <= '{we: req_we, waddr: req_waddr, wdata: req_wdata,
                           raddr_a: req_raddr_a, raddr_b: req_raddr_b};
            rs_addr   <= req_raddr_a;
            rt_addr   <= req_raddr_b;
            rd_addr   <= req_waddr;
            rd_w_data <= req_wdata;
            r_write   <= req_we && (req_waddr != '0);
            req_ready <= 1'b0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_a <= byp_a;
          rsp_data_b <= byp_b;
          rsp_valid  <= 1'b1;
          r_write    <= 1'b0;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl with an attached behavioural register file.
module tb_regfile_ctrl;

  localparam int ADDR  = 5;
  localparam int BUS_W = 32;
  localparam int DEPTH = 1 << ADDR;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_we;
  logic [ADDR-1:0]  req_waddr, req_raddr_a, req_raddr_b;
  logic [BUS_W-1:0] req_wdata;
  logic             rsp_valid, rsp_ready;
  logic [BUS_W-1:0] rsp_data_a, rsp_data_b;
  logic             init_done, r_write;
  logic [ADDR-1:0]  rd_addr, rs_addr, rt_addr;
  logic [BUS_W-1:0] rd_w_data, rs_data, rt_data;

  always #5 clk = ~clk;

  regfile_ctrl #(.ADDR(ADDR), .BUS_W(BUS_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_waddr(req_waddr), .req_wdata(req_wdata),
    .req_raddr_a(req_raddr_a), .req_raddr_b(req_raddr_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .init_done(init_done), .r_write(r_write), .rd_addr(rd_addr),
    .rd_w_data(rd_w_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data)
  );

  // Attached register file, seeded with garbage so the clear sweep and the zero-register rule matter.
  logic [BUS_W-1:0] rf [DEPTH];
  bit rf_seeded = 1'b0;
  int zero_writes = 0;
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= $urandom | 32'h1;
      rf_seeded <= 1'b1;
    end else if (r_write) begin
      rf[rd_addr] <= rd_w_data;
    end
    if (r_write && rd_addr == '0) zero_writes++;
  end
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  // Reference model: architectural register contents as seen by completed requests.
  logic [BUS_W-1:0] ref_rf [DEPTH];

  typedef struct {
    logic             we;
    logic [ADDR-1:0]  waddr;
    logic [BUS_W-1:0] wdata;
    logic [ADDR-1:0]  ra;
    logic [ADDR-1:0]  rb;
    logic [BUS_W-1:0] exp_a;
    logic [BUS_W-1:0] exp_b;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic timed_out(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  function automatic logic [BUS_W-1:0] model_read(input vec_t v, input logic [ADDR-1:0] a);
    if (a == 0) return '0;
    if (v.we && v.waddr != 0 && a == v.waddr) return v.wdata;
    return ref_rf[a];
  endfunction

  task automatic wait_ready(input string nm, output bit ok);
    int n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) timed_out(nm);
  endtask

  task automatic apply(input vec_t v, input string nm);
    bit ok;
    bit wr;
    @(negedge clk);
    req_we = v.we; req_waddr = v.waddr; req_wdata = v.wdata;
    req_raddr_a = v.ra; req_raddr_b = v.rb; req_valid = 1'b1;
    wait_ready({nm, "_ready"}, ok);
    if (!ok) begin
      req_valid = 1'b0;
      return;
    end
    wr = v.we && (v.waddr != 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_rwrite"}, 32'(r_write), 32'(wr));
    chk({nm, "_rs_addr"}, 32'(rs_addr), 32'(v.ra));
    chk({nm, "_rt_addr"}, 32'(rt_addr), 32'(v.rb));
    if (wr) begin
      chk({nm, "_rd_addr"}, 32'(rd_addr), 32'(v.waddr));
      chk({nm, "_rd_w_data"}, rd_w_data, v.wdata);
    end
    chk({nm, "_rsp_early"}, 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'(1));
    chk({nm, "_data_a"}, rsp_data_a, v.exp_a);
    chk({nm, "_data_b"}, rsp_data_b, v.exp_b);
    if (wr) ref_rf[v.waddr] = v.wdata;
  endtask

  task automatic wait_init_done(input string nm);
    int n = 0;
    while (!init_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!init_done) timed_out(nm);
    for (int i = 0; i < DEPTH; i++) ref_rf[i] = '0;
  endtask

  vec_t dir [6];
  vec_t v;
  bit   ok;

  initial begin
    dir[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd7, 32'h0, 32'h0};
    dir[1] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
    dir[2] = '{1'b1, 5'd9, 32'h12345678, 5'd9, 5'd9, 32'h12345678, 32'h12345678};
    dir[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF};
    dir[4] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 32'h0, 32'h12345678};
    dir[5] = '{1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd31, 32'hA5A5A5A5, 32'h0};

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_waddr = '0; req_wdata = '0;
    req_raddr_a = '0; req_raddr_b = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_init_done", 32'(init_done), 32'(0));
    chk("rst_r_write", 32'(r_write), 32'(0));
    chk("rst_rd_addr", 32'(rd_addr), 32'(0));
    rst = 1'b1;

    // Clear sweep: one zero write per cycle to 1..31, then ready.
    for (int k = 1; k < DEPTH; k++) begin
      @(negedge clk);
      chk($sformatf("init_rwrite_%0d", k), 32'(r_write), 32'(1));
      chk($sformatf("init_addr_%0d", k), 32'(rd_addr), 32'(k));
      chk($sformatf("init_data_%0d", k), rd_w_data, 32'(0));
      chk($sformatf("init_ready_%0d", k), 32'(req_ready), 32'(0));
    end
    @(negedge clk);
    chk("init_done", 32'(init_done), 32'(1));
    chk("init_ready_after", 32'(req_ready), 32'(1));
    chk("init_rwrite_after", 32'(r_write), 32'(0));
    for (int i = 0; i < DEPTH; i++) ref_rf[i] = '0;

    foreach (dir[i]) apply(dir[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.waddr = ADDR'($urandom_range(0, 7));
      v.wdata = $urandom;
      v.ra    = ADDR'($urandom_range(0, 7));
      v.rb    = ADDR'($urandom_range(0, 7));
      v.exp_a = model_read(v, v.ra);
      v.exp_b = model_read(v, v.rb);
      apply(v, $sformatf("rnd%0d", i));
    end

    // Backpressure: response held 5 cycles while the next request waits.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_we = 1'b1; req_waddr = 5'd3; req_wdata = 32'h33330003;
    req_raddr_a = 5'd3; req_raddr_b = 5'd0; req_valid = 1'b1;
    wait_ready("bp_ready", ok);
    @(negedge clk);
    req_we = 1'b0; req_raddr_a = 5'd3; req_raddr_b = 5'd3;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_data_a", rsp_data_a, 32'h33330003);
      chk("bp_data_b", rsp_data_b, 32'h0);
      chk("bp_req_ready", 32'(req_ready), 32'(0));
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(req_ready), 32'(1));
    chk("bp_release_valid", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("bp_next_accepted", 32'(req_ready), 32'(0));
    chk("bp_next_rs_addr", 32'(rs_addr), 32'(3));
    req_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", 32'(rsp_valid), 32'(1));
    chk("bp_next_a", rsp_data_a, 32'h33330003);
    chk("bp_next_b", rsp_data_b, 32'h33330003);

    // Reset while a response is pending.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_we = 1'b0; req_raddr_a = 5'd3; req_raddr_b = 5'd5; req_valid = 1'b1;
    wait_ready("mr_ready", ok);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mr_resp_before", 32'(rsp_valid), 32'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mr_rsp_data_a", rsp_data_a, 32'h0);
    chk("mr_req_ready", 32'(req_ready), 32'(0));
    chk("mr_init_done", 32'(init_done), 32'(0));
    chk("mr_r_write", 32'(r_write), 32'(0));
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mr_sweep_start_w", 32'(r_write), 32'(1));
    chk("mr_sweep_start_a", 32'(rd_addr), 32'(1));

    // Reset part-way through the sweep, at address 12.
    begin
      int n = 0;
      while (!(r_write && rd_addr == 5'd12) && n < 64) begin
        @(negedge clk);
        n++;
      end
      if (!(r_write && rd_addr == 5'd12)) timed_out("mi_reach_12");
    end
    rst = 1'b0;
    @(negedge clk);
    chk("mi_r_write", 32'(r_write), 32'(0));
    chk("mi_rd_addr", 32'(rd_addr), 32'(0));
    chk("mi_rsp_valid", 32'(rsp_valid), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("mi_restart_w", 32'(r_write), 32'(1));
    chk("mi_restart_a", 32'(rd_addr), 32'(1));
    wait_init_done("mi_init_done");

    v = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd3, 32'h0, 32'h0};
    apply(v, "post_rst0");
    v = '{1'b1, 5'd7, 32'h0BADF00D, 5'd9, 5'd7, 32'h0, 32'h0BADF00D};
    apply(v, "post_rst1");

    @(negedge clk);
    chk("zero_reg_writes", 32'(zero_writes), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
